// File: rtl/fir_regs_pkg.sv
// Shared register-map addresses, CTRL/STATUS bit positions and run-state
// encoding for the FIR register bank.
package fir_regs_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'h20;
    localparam logic [5:0] ADDR_STATUS = 6'h21;
    localparam logic [5:0] ADDR_NSAMP  = 6'h22;
    localparam logic [5:0] ADDR_SCNT   = 6'h23;
    localparam logic [5:0] ADDR_ID     = 6'h3F;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_CLR    = 3;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_WR_ERR = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// FIR coefficient storage: one bus write port and two registered read ports
// (bus side and datapath side). Out-of-range indices read as zero.
module fir_coef_bank #(
    parameter int N_TAPS = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        bus_addr,
    output logic [DATA_W-1:0] bus_data,
    input  logic [4:0]        dp_addr,
    output logic [DATA_W-1:0] dp_data
);

    logic [DATA_W-1:0] coef [N_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < N_TAPS)) begin
            coef[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data <= '0;
            dp_data  <= '0;
        end else begin
            bus_data <= (int'(bus_addr) < N_TAPS) ? coef[bus_addr] : '0;
            dp_data  <= (int'(dp_addr)  < N_TAPS) ? coef[dp_addr]  : '0;
        end
    end

endmodule

// File: rtl/fir_reg_bank.sv
// Register bank and run controller for the FIR datapath: bus decode,
// CTRL/STATUS/count registers, IDLE/RUN/DONE sequencing and read mux.
module fir_reg_bank
    import fir_regs_pkg::*;
#(
    parameter int                N_TAPS   = 32,
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hF1A0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [ADDR_W-1:0] p_address,
    input  logic [DATA_W-1:0] p_data,
    input  logic              p_wr,
    output logic [DATA_W-1:0] p_data_back,
    input  logic [4:0]        coef_addr,
    output logic [DATA_W-1:0] coef_data,
    input  logic              fir_sample_strobe,
    output logic              fir_enable,
    output logic              fir_start,
    output logic              irq
);

    state_t            state;
    logic              irq_en;
    logic              done;
    logic              wr_err;
    logic [DATA_W-1:0] num_samples;
    logic [DATA_W-1:0] sample_cnt;

    logic              addr_is_coef;
    logic              wr_coef, wr_ctrl, wr_status, wr_nsamp;
    logic              busy;
    logic              start_req, abort_req, clr_req;
    logic              start_ok, start_bad;
    logic              strobe_hit;
    logic [DATA_W-1:0] cnt_inc;
    logic              err_set, done_set;
    logic              done_clr, err_clr;

    logic              rd_coef_sel;
    logic [DATA_W-1:0] rd_reg;
    logic [DATA_W-1:0] reg_rdata;
    logic [DATA_W-1:0] coef_bus_data;

    assign addr_is_coef = (p_address[ADDR_W-1] == 1'b0) && (int'(p_address[4:0]) < N_TAPS);
    assign wr_coef      = p_wr && addr_is_coef;
    assign wr_ctrl      = p_wr && (p_address == ADDR_CTRL);
    assign wr_status    = p_wr && (p_address == ADDR_STATUS);
    assign wr_nsamp     = p_wr && (p_address == ADDR_NSAMP);

    assign busy      = (state == RUN);
    assign start_req = wr_ctrl && p_data[CTRL_START];
    assign abort_req = wr_ctrl && p_data[CTRL_ABORT];
    assign clr_req   = wr_ctrl && p_data[CTRL_CLR];

    // A start is only honoured from IDLE with a non-zero run length; anything
    // else is flagged rather than silently lost.
    assign start_ok   = start_req && (state == IDLE) && (num_samples != '0);
    assign start_bad  = start_req && !start_ok;
    assign strobe_hit = busy && fir_sample_strobe && !abort_req;
    assign cnt_inc    = (sample_cnt == '1) ? sample_cnt : sample_cnt + 1'b1;

    assign err_set  = ((wr_coef || wr_nsamp) && busy) || start_bad;
    assign done_set = (state == DONE);
    assign done_clr = clr_req || (wr_status && p_data[STAT_DONE]);
    assign err_clr  = clr_req || (wr_status && p_data[STAT_WR_ERR]);

    assign irq = done && irq_en;

    fir_coef_bank #(
        .N_TAPS (N_TAPS),
        .DATA_W (DATA_W)
    ) u_coef_bank (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .wr_en    (wr_coef && !busy),
        .wr_addr  (p_address[4:0]),
        .wr_data  (p_data),
        .bus_addr (p_address[4:0]),
        .bus_data (coef_bus_data),
        .dp_addr  (coef_addr),
        .dp_data  (coef_data)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            fir_start  <= 1'b0;
            fir_enable <= 1'b0;
        end else begin
            fir_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= RUN;
                        fir_start  <= 1'b1;
                        fir_enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        state      <= IDLE;
                        fir_enable <= 1'b0;
                    end else if (strobe_hit && (cnt_inc == num_samples)) begin
                        state      <= DONE;
                        fir_enable <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    fir_enable <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    fir_enable <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as any clear always wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en      <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            num_samples <= '0;
            sample_cnt  <= '0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= p_data[CTRL_IRQ_EN];
            end
            if (wr_nsamp && !busy) begin
                num_samples <= p_data;
            end

            if (done_set) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end

            if (err_set) begin
                wr_err <= 1'b1;
            end else if (err_clr) begin
                wr_err <= 1'b0;
            end

            if (start_ok) begin
                sample_cnt <= '0;
            end else if (strobe_hit) begin
                sample_cnt <= cnt_inc;
            end else if (clr_req) begin
                sample_cnt <= '0;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (p_address)
            ADDR_CTRL:   reg_rdata[CTRL_IRQ_EN] = irq_en;
            ADDR_STATUS: begin
                reg_rdata[STAT_BUSY]   = busy;
                reg_rdata[STAT_DONE]   = done;
                reg_rdata[STAT_WR_ERR] = wr_err;
            end
            ADDR_NSAMP:  reg_rdata = num_samples;
            ADDR_SCNT:   reg_rdata = sample_cnt;
            ADDR_ID:     reg_rdata = ID_VALUE;
            default:     reg_rdata = '0;
        endcase
    end

    // Coefficient reads come back already registered from the bank, so only
    // the selection is delayed here to keep both paths at one cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rd_coef_sel <= 1'b0;
            rd_reg      <= '0;
        end else begin
            rd_coef_sel <= addr_is_coef;
            rd_reg      <= reg_rdata;
        end
    end

    assign p_data_back = rd_coef_sel ? coef_bus_data : rd_reg;

endmodule

// File: tb/tb_fir_reg_bank.sv
// Directed testbench for fir_reg_bank: bus reads/writes, run sequencing,
// error flags, abort handling and asynchronous reset.
module tb_fir_reg_bank;

    logic        PCLK;
    logic        PRESETn;
    logic [5:0]  p_address;
    logic [15:0] p_data;
    logic        p_wr;
    logic [15:0] p_data_back;
    logic [4:0]  coef_addr;
    logic [15:0] coef_data;
    logic        fir_sample_strobe;
    logic        fir_enable;
    logic        fir_start;
    logic        irq;

    int vectors_applied = 0;
    int miscompares     = 0;
    logic [15:0] rd_val;

    fir_reg_bank dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .p_address         (p_address),
        .p_data            (p_data),
        .p_wr              (p_wr),
        .p_data_back       (p_data_back),
        .coef_addr         (coef_addr),
        .coef_data         (coef_data),
        .fir_sample_strobe (fir_sample_strobe),
        .fir_enable        (fir_enable),
        .fir_start         (fir_start),
        .irq               (irq)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle bus write, driven on the falling edge.
    task automatic applyStimulus(input logic [5:0] addr, input logic [15:0] data);
        @(negedge PCLK);
        p_address = addr;
        p_data    = data;
        p_wr      = 1'b1;
        @(negedge PCLK);
        p_wr      = 1'b0;
    endtask

    task automatic readReg(input logic [5:0] addr, output logic [15:0] val);
        @(negedge PCLK);
        p_address = addr;
        p_wr      = 1'b0;
        @(negedge PCLK);
        val = p_data_back;
    endtask

    task automatic pulseStrobe();
        @(negedge PCLK);
        fir_sample_strobe = 1'b1;
        @(negedge PCLK);
        fir_sample_strobe = 1'b0;
    endtask

    initial begin
        PRESETn           = 1'b0;
        p_address         = '0;
        p_data            = '0;
        p_wr              = 1'b0;
        coef_addr         = '0;
        fir_sample_strobe = 1'b0;

        #12;
        checkOutput("rst_p_data_back", p_data_back, 16'h0000);
        checkOutput("rst_fir_enable", fir_enable, 1'b0);
        checkOutput("rst_fir_start", fir_start, 1'b0);
        checkOutput("rst_irq", irq, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Identity and idle status
        readReg(6'h3F, rd_val);
        checkOutput("id_read", rd_val, 16'hF1A0);
        readReg(6'h21, rd_val);
        checkOutput("status_after_reset", rd_val, 16'h0000);

        // Coefficient write, datapath and bus readback, unmapped access
        applyStimulus(6'h05, 16'h1234);
        @(negedge PCLK);
        coef_addr = 5'd5;
        @(negedge PCLK);
        checkOutput("coef_data_5", coef_data, 16'h1234);
        readReg(6'h05, rd_val);
        checkOutput("bus_coef_5", rd_val, 16'h1234);
        applyStimulus(6'h30, 16'hFFFF);
        readReg(6'h30, rd_val);
        checkOutput("unmapped_read", rd_val, 16'h0000);
        readReg(6'h21, rd_val);
        checkOutput("unmapped_no_err", rd_val, 16'h0000);

        // Full run of three samples with interrupt
        applyStimulus(6'h22, 16'd3);
        applyStimulus(6'h20, 16'h0005);
        checkOutput("run_fir_start_hi", fir_start, 1'b1);
        checkOutput("run_fir_enable_hi", fir_enable, 1'b1);
        @(negedge PCLK);
        checkOutput("run_fir_start_lo", fir_start, 1'b0);
        readReg(6'h21, rd_val);
        checkOutput("run_busy", rd_val, 16'h0001);
        pulseStrobe();
        pulseStrobe();
        pulseStrobe();
        readReg(6'h23, rd_val);
        checkOutput("run_sample_cnt", rd_val, 16'd3);
        checkOutput("run_irq", irq, 1'b1);
        checkOutput("run_fir_enable_lo", fir_enable, 1'b0);
        readReg(6'h21, rd_val);
        checkOutput("run_done", rd_val, 16'h0002);
        applyStimulus(6'h21, 16'h0002);
        checkOutput("w1c_irq", irq, 1'b0);
        readReg(6'h21, rd_val);
        checkOutput("w1c_status", rd_val, 16'h0000);

        // Illegal writes while busy and zero-length start
        applyStimulus(6'h20, 16'h0005);
        applyStimulus(6'h00, 16'hBEEF);
        readReg(6'h21, rd_val);
        checkOutput("busy_wr_err", rd_val, 16'h0005);
        applyStimulus(6'h20, 16'h0006);
        readReg(6'h00, rd_val);
        checkOutput("coef0_unchanged", rd_val, 16'h0000);
        applyStimulus(6'h20, 16'h000C);
        readReg(6'h21, rd_val);
        checkOutput("clr_status", rd_val, 16'h0000);
        applyStimulus(6'h22, 16'd0);
        applyStimulus(6'h20, 16'h0005);
        checkOutput("zero_start_enable", fir_enable, 1'b0);
        checkOutput("zero_start_pulse", fir_start, 1'b0);
        readReg(6'h21, rd_val);
        checkOutput("zero_start_err", rd_val, 16'h0004);
        applyStimulus(6'h21, 16'h0004);

        // Abort with simultaneous strobe at count 1
        applyStimulus(6'h22, 16'd5);
        applyStimulus(6'h20, 16'h0005);
        pulseStrobe();
        @(negedge PCLK);
        p_address         = 6'h20;
        p_data            = 16'h0006;
        p_wr              = 1'b1;
        fir_sample_strobe = 1'b1;
        @(negedge PCLK);
        p_wr              = 1'b0;
        fir_sample_strobe = 1'b0;
        checkOutput("abort_enable", fir_enable, 1'b0);
        readReg(6'h23, rd_val);
        checkOutput("abort_cnt", rd_val, 16'd1);
        readReg(6'h21, rd_val);
        checkOutput("abort_status", rd_val, 16'h0000);
        checkOutput("abort_irq", irq, 1'b0);

        // Reset in the middle of a run with a pending interrupt
        applyStimulus(6'h22, 16'd1);
        applyStimulus(6'h20, 16'h0005);
        pulseStrobe();
        applyStimulus(6'h22, 16'd5);
        applyStimulus(6'h20, 16'h0005);
        @(negedge PCLK);
        p_address = 6'h3F;
        @(negedge PCLK);
        checkOutput("pre_rst_irq", irq, 1'b1);
        checkOutput("pre_rst_enable", fir_enable, 1'b1);
        checkOutput("pre_rst_data", p_data_back, 16'hF1A0);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("mid_rst_enable", fir_enable, 1'b0);
        checkOutput("mid_rst_irq", irq, 1'b0);
        checkOutput("mid_rst_data", p_data_back, 16'h0000);
        @(negedge PCLK);
        PRESETn = 1'b1;
        readReg(6'h05, rd_val);
        checkOutput("post_rst_coef5", rd_val, 16'h0000);
        readReg(6'h20, rd_val);
        checkOutput("post_rst_ctrl", rd_val, 16'h0000);
        readReg(6'h21, rd_val);
        checkOutput("post_rst_status", rd_val, 16'h0000);
        readReg(6'h22, rd_val);
        checkOutput("post_rst_nsamp", rd_val, 16'h0000);
        readReg(6'h23, rd_val);
        checkOutput("post_rst_scnt", rd_val, 16'h0000);
        readReg(6'h3F, rd_val);
        checkOutput("post_rst_id", rd_val, 16'hF1A0);
        checkOutput("post_rst_coef_data", coef_data, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_reg_bank.md
Name: fir_reg_bank

Overview:
- Register bank and run controller that consumes the internal peripheral bus (p_address/p_data/p_wr) produced by the APB3 slave bridge, and returns p_data_back to it.
- Holds the FIR coefficient bank plus CTRL, STATUS, NUM_SAMPLES, SAMPLE_CNT and ID registers.
- Sequences a run of the FIR datapath (IDLE/RUN/DONE) and raises an interrupt on completion.
- Single clock domain. Read data is stable well within the bridge's 5 read wait states.

Parameters:
- N_TAPS, 32, number of 16-bit coefficient registers at addresses 0x00..N_TAPS-1 (≤32).
- DATA_W, 16, peripheral data width.
- ADDR_W, 6, peripheral address width.
- ID_VALUE, 16'hF1A0, constant returned at address 0x3F.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- p_address  in  6  register address from bridge.
- p_data  in  16  write data from bridge.
- p_wr  in  1  one-cycle write strobe.
- p_data_back  out  16  registered read data to bridge.
- coef_addr  in  5  FIR datapath coefficient index.
- coef_data  out  16  coefficient at coef_addr, 1-cycle latency.
- fir_sample_strobe  in  1  one pulse per output sample produced by the FIR datapath.
- fir_enable  out  1  high while in RUN.
- fir_start  out  1  one-cycle pulse on IDLE->RUN.
- irq  out  1  level interrupt = STATUS.done & CTRL.irq_en.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - All outputs 0; coefficients, CTRL, STATUS, NUM_SAMPLES and SAMPLE_CNT are 0; FSM goes to IDLE.
  - Reset mid-RUN aborts immediately with no done flag.
- Register map:
  - 0x00..N_TAPS-1: COEF, RW.
  - 0x20: CTRL. [0] start (write-1 pulse, reads 0); [1] abort (write-1 pulse, reads 0); [2] irq_en (RW); [3] clr (write-1 pulse: clears SAMPLE_CNT, done, wr_err).
  - 0x21: STATUS. [0] busy (RO, =RUN); [1] done (sticky, W1C); [2] wr_err (sticky, W1C).
  - 0x22: NUM_SAMPLES, RW.
  - 0x23: SAMPLE_CNT, RO, 16-bit.
  - 0x3F: ID, RO.
  - Unmapped addresses read 0; writes to them are ignored without error.
- Read path: p_data_back is registered every cycle from p_address, so latency is 1 cycle. A write and a read of the same register in the same cycle returns the old value.
- Write legality: writes to COEF or NUM_SAMPLES while busy are dropped and set wr_err. A start while busy, or a start with NUM_SAMPLES==0, is dropped and sets wr_err.
- FSM states:
  - IDLE: on a legal start, go to RUN, clear SAMPLE_CNT, pulse fir_start for 1 cycle.
  - RUN: fir_enable=1. Each fir_sample_strobe increments SAMPLE_CNT. A strobe that makes SAMPLE_CNT == NUM_SAMPLES goes to DONE.
    - An abort in RUN returns to IDLE, leaves done unchanged, and freezes SAMPLE_CNT.
    - If abort and strobe arrive in the same cycle, abort wins and the count does not increment.
  - DONE: lasts 1 cycle. Sets done and drops fir_enable, then goes to IDLE.
- SAMPLE_CNT saturates at 16'hFFFF.
- Strobes are ignored outside RUN.
- Set/clear conflicts:
  - W1C of done in the same cycle the DONE state sets it: set wins.
  - clr in the same cycle as a done set: set wins.
- coef_data = coef[coef_addr], registered, 1-cycle latency. Returns 0 when coef_addr ≥ N_TAPS.
- irq is combinational from registered bits; no pulse behaviour.

Decomposition:
- Package fir_regs_pkg:
  - address localparams: ADDR_CTRL, ADDR_STATUS, ADDR_NSAMP, ADDR_SCNT, ADDR_ID.
  - CTRL/STATUS bit-index constants.
  - state enum: IDLE, RUN, DONE.
- Sub-module fir_coef_bank: N_TAPS×16 register array with one write port (bus) and two registered read ports (bus, datapath).
- Top: decode, control/status registers, FSM, read mux.

Test Plan:
1. Reset, then read 0x3F -> p_data_back=16'hF1A0 one cycle after the address is applied. Read 0x21 -> 0.
2. Write COEF[5]=16'h1234 in IDLE; drive coef_addr=5 -> coef_data=16'h1234 next cycle. Bus read of 0x05 -> 16'h1234.
3. NUM_SAMPLES=3, irq_en=1, start -> fir_start pulses once and busy=1. After 3 strobes -> SAMPLE_CNT=3, done=1, irq=1, fir_enable=0. W1C 0x21=16'h0002 -> irq=0.
4. In RUN, write COEF[0]=16'hBEEF -> COEF[0] unchanged and wr_err=1. Start with NUM_SAMPLES=0 -> stays IDLE and wr_err=1.
5. In RUN at SAMPLE_CNT=1, abort with a simultaneous strobe -> IDLE, SAMPLE_CNT=1, done=0, irq=0.
6. Assert PRESETn low mid-RUN -> fir_enable, irq and p_data_back go to 0 immediately. After release, all registers read 0 and ID reads 16'hF1A0.
